// File: rtl/phase3_pkg.sv
// rtl/phase3_pkg.sv - phase-3 shared types and constants
package phase3_pkg;

    // Default rotated bitstream word width, shared with the phase-3b rotator
    localparam int P3_BITSTREAM = 64;

    // Popcount accumulator states
    typedef enum logic [1:0] {
        P3C_ACCUM = 2'd0,
        P3C_DRAIN = 2'd1,
        P3C_HOLD  = 2'd2
    } p3c_state_t;

endpackage

// File: rtl/phase_3c_popcnt.sv
// rtl/phase_3c_popcnt.sv - combinational adder-tree popcount, W must be a power of two
module phase_3c_popcnt #(
    parameter int W = 64,
    localparam int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [OW-1:0] count
);

    generate
        if (W == 1) begin : g_leaf
            assign count = bits;
        end else begin : g_node
            // Each half counts into one bit less than this level's output
            localparam int HW  = W / 2;
            localparam int HOW = $clog2(HW + 1);

            logic [HOW-1:0] lo_cnt;
            logic [HOW-1:0] hi_cnt;

            phase_3c_popcnt #(.W(HW)) u_lo (
                .bits  (bits[HW-1:0]),
                .count (lo_cnt)
            );

            phase_3c_popcnt #(.W(HW)) u_hi (
                .bits  (bits[W-1:HW]),
                .count (hi_cnt)
            );

            assign count = {1'b0, lo_cnt} + {1'b0, hi_cnt};
        end
    endgenerate

endmodule

// File: rtl/phase_3c_popacc.sv
// rtl/phase_3c_popacc.sv - popcount accumulator over FRAMES words; PHASE3C_POP_REG_EN registers the popcount
module phase_3c_popacc
    import phase3_pkg::*;
#(
    parameter int BITSTREAM = P3_BITSTREAM,
    parameter int FRAMES    = 8,
    localparam int CNT_W    = $clog2(BITSTREAM * FRAMES + 1),
    localparam int FI_W     = $clog2(FRAMES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BITSTREAM-1:0] in_bits,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     out_count,
    output logic [FI_W-1:0]      frame_idx
);

    localparam int              PC_W     = $clog2(BITSTREAM + 1);
    localparam logic [FI_W-1:0] LAST_IDX = FI_W'(FRAMES - 1);

    p3c_state_t       state;
    p3c_state_t       state_nxt;
    logic [CNT_W-1:0] acc;
    logic [PC_W-1:0]  pc;
    logic             accept;
    logic             last_accept;

    phase_3c_popcnt #(.W(BITSTREAM)) u_popcnt (
        .bits  (in_bits),
        .count (pc)
    );

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (frame_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= P3C_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs, decoded from the registered state only
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            P3C_ACCUM: begin
                in_ready = 1'b1;
                if (last_accept) begin
`ifdef PHASE3C_POP_REG_EN
                    state_nxt = P3C_DRAIN;
`else
                    state_nxt = P3C_HOLD;
`endif
                end
            end
            P3C_DRAIN: begin
                state_nxt = P3C_HOLD;
            end
            P3C_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = P3C_ACCUM;
                end
            end
            default: begin
                state_nxt = P3C_ACCUM;
            end
        endcase
        if (clr) begin
            state_nxt = P3C_ACCUM;
        end
    end

`ifdef PHASE3C_POP_REG_EN
    logic [PC_W-1:0] pc_q;

    // Pipelined datapath: pc_q carries last cycle's popcount (zero when nothing was accepted)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            acc       <= '0;
            frame_idx <= '0;
            out_count <= '0;
        end else if (clr) begin
            pc_q      <= '0;
            acc       <= '0;
            frame_idx <= '0;
        end else begin
            pc_q <= accept ? pc : '0;
            if (accept) begin
                frame_idx <= frame_idx + FI_W'(1);
            end
            if (state == P3C_ACCUM) begin
                acc <= acc + CNT_W'(pc_q);
            end
            if (state == P3C_DRAIN) begin
                out_count <= acc + CNT_W'(pc_q);
            end
            if ((state == P3C_HOLD) && out_ready) begin
                acc       <= '0;
                frame_idx <= '0;
            end
        end
    end
`else
    // Single-cycle datapath: popcount and add in the accepting cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            frame_idx <= '0;
            out_count <= '0;
        end else if (clr) begin
            acc       <= '0;
            frame_idx <= '0;
        end else begin
            if (accept) begin
                acc       <= acc + CNT_W'(pc);
                frame_idx <= frame_idx + FI_W'(1);
            end
            if (last_accept) begin
                out_count <= acc + CNT_W'(pc);
            end
            if ((state == P3C_HOLD) && out_ready) begin
                acc       <= '0;
                frame_idx <= '0;
            end
        end
    end
`endif

endmodule

// File: doc/phase_3c_popacc.md
# phase_3c_popacc

Downstream consumer of the phase-3b rotator: accepts rotated `BITSTREAM`-bit words over a valid/ready handshake and popcounts each word. It accumulates the counts over `FRAMES` consecutive words and presents the total as one decoded stochastic value on a second valid/ready handshake. The block closes phase 3, turning rotated bitstreams back into a binary count for the next phase.

## Interface
- `BITSTREAM`, 64: width of each input word; must be ≥ 4 and a power of two.
- `FRAMES`, 8: number of words accumulated per result; ≥ 1.
- `CNT_W`, `$clog2(BITSTREAM*FRAMES+1)`: result width; derived, not overridden.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous abort: discard partial accumulation, return to ACCUM.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept a word.
- `in_bits`  in  BITSTREAM  rotated bitstream word from phase 3b.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_count`  out  CNT_W  total ones over the last `FRAMES` words.
- `frame_idx`  out  `$clog2(FRAMES+1)`  words accepted in the current accumulation.

## Operation
- States: ACCUM, DRAIN (only with macro), HOLD.
- ACCUM: `in_ready`=1. On each accept (`in_valid && in_ready`), `acc += popcount(in_bits)` and `frame_idx++`.
- On the `FRAMES`-th accept:
  - without macro: the final sum is written to `out_count`, `out_valid`=1, and the state goes to HOLD.
  - with macro: the state goes to DRAIN.
- DRAIN: `in_ready`=0. The registered popcount of the last word is added, the result is loaded into `out_count`, `out_valid`=1, and the state goes to HOLD.
- HOLD: `in_ready`=0. `out_count` is stable while `out_valid && !out_ready`. On `out_ready`: `out_valid`=0, `acc`=0, `frame_idx`=0, and the state goes to ACCUM.
- Arithmetic:
  - popcount is `$clog2(BITSTREAM+1)` bits wide, zero-extended to `CNT_W`.
  - The accumulator cannot overflow, since the maximum is `BITSTREAM*FRAMES`.
  - `FRAMES`=1 is legal: every word produces a result.
- `clr` has priority over all other events:
  - next cycle: state ACCUM, `acc`=0, `frame_idx`=0, `out_valid`=0, any pipeline register cleared.
  - A word presented in the same cycle as `clr` is not counted.
  - A pending result in HOLD is dropped.
- `in_bits` is ignored when `in_valid`=0. `out_count` holds its last value when `out_valid`=0.

## Timing
- Reset values: state ACCUM, `in_ready`=1 (combinational from state, so it reads 1 after reset), `out_valid`=0, `out_count`=0, `frame_idx`=0, `acc`=0.
- Throughput in ACCUM: one word per cycle.
- Latency from the last accept at edge T:
  - without macro: `out_valid` high after edge T+1.
  - with macro: `out_valid` high after edge T+2.
- Output handshake at edge H: `in_ready`=1 after edge H+1. There is no same-cycle pass-through; there is one bubble per result.
- `in_ready` and `out_valid` are functions of registered state only, with no combinational path from `in_valid` or `out_ready`.
- Reset asserted mid-accumulation or in HOLD: all registers return to their reset values immediately. No partial result is emitted.

## Configuration
- `PHASE3C_POP_REG_EN`
  - defined: the popcount is registered before the add, the DRAIN state exists, and result latency is +1 cycle. Used for timing closure at `BITSTREAM` ≥ 128.
  - undefined: popcount and add happen in the same cycle and DRAIN is never entered.
- Handshake rules and results are identical either way.

## Structure
- Shared package `phase3_pkg`: state enum (`P3C_ACCUM`, `P3C_DRAIN`, `P3C_HOLD`) and the `BITSTREAM` default constant, shared with the phase-3b rotator.
- One sub-module, `phase_3c_popcnt`: a parameterized combinational adder-tree popcount (width `BITSTREAM`, output `$clog2(BITSTREAM+1)`).
- FSM, accumulator and optional pipeline register live in `phase_3c_popacc`.

## Test plan
- Reset, then send 8 words of `64'hFFFF_FFFF_FFFF_FFFF` back-to-back, `out_ready`=1 -> `out_count`=512, one `out_valid` pulse, latency as in Timing.
- 8 words of `64'h0000_0000_0000_0001` with random `in_valid` gaps -> `out_count`=8; `frame_idx` steps 0..8.
- Hold `out_ready`=0 for 5 cycles after the result -> `out_valid` and `out_count` stable, `in_ready`=0; then `out_ready`=1 -> `in_ready`=1 the next cycle.
- Accept 3 words of `64'h00FF_00FF_00FF_00FF`, pulse `clr`, then send 8 words of `64'hF000_0000_0000_000F` -> `out_count`=64 (8 per word), no contribution from the first 3.
- Assert `rst_n`=0 asynchronously while in HOLD -> `out_valid`=0, `out_count`=0 before the next clock edge.
- Repeat all scenarios with `PHASE3C_POP_REG_EN` defined and `FRAMES`=1 -> identical counts, +1 latency, one result per word.
